mult_div_ctrl: RTL

//  Sequences the shared 32-bit Booth multiplier and the divider for MULT/MULTU-style and DIV instructions.

---
 rtl/mult_div_ctrl_pkg.sv | 33 +++
 rtl/mult_div_ctrl_hi_lo_regs.sv | 46 ++++
 rtl/mult_div_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mult_div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_ctrl_pkg
// Purpose : Shared definitions for the multiply/divide sequencer: the
//           controller state encoding, default widths and watchdog limit,
//           and a small helper that identifies the two waiting states.
// Contents: WIDTH_DEF, MAX_CICLOS_DEF, CNT_W_DEF, ctrl_state_t, isWaitState()
// ---------------------------------------------------------------------------
package mult_div_ctrl_pkg;

  // Operand/result width of the shared arithmetic units
  localparam int WIDTH_DEF      = 32;

  // Watchdog limit in waiting-state cycles, and the width of its counter.
  // The counter must be able to hold MAX_CICLOS, so 2**CNT_W > MAX_CICLOS.
  localparam int MAX_CICLOS_DEF = 48;
  localparam int CNT_W_DEF      = 6;

  // Controller states: one start/wait pair per arithmetic unit
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    M_START = 3'd1,
    M_WAIT  = 3'd2,
    D_START = 3'd3,
    D_WAIT  = 3'd4
  } ctrl_state_t;

  // True in the states where a unit's busy flag is meaningful and the
  // watchdog is running
  function automatic logic isWaitState(input ctrl_state_t s);
    return (s == M_WAIT) || (s == D_WAIT);
  endfunction

endpackage

// File: rtl/mult_div_ctrl_hi_lo_regs.sv
// ---------------------------------------------------------------------------
// hi_lo_regs
// Purpose : The architectural HI and LO registers read by MFHI/MFLO.
//           Each register has its own write enable; the controller chooses
//           whether the write data comes from the multiplier or the divider.
// Ports   : clk        rising-edge clock
//           reset      synchronous, active-high; clears both registers
//           i_hiWe     write enable for HI
//           i_loWe     write enable for LO
//           i_hiData   data written into HI
//           i_loData   data written into LO
//           o_hi       current HI value
//           o_lo       current LO value
// ---------------------------------------------------------------------------
module hi_lo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_hiWe,
  input  logic             i_loWe,
  input  logic [WIDTH-1:0] i_hiData,
  input  logic [WIDTH-1:0] i_loData,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // HI and LO hold their value until the controller captures a finished
  // result; reset returns both to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_hiWe) r_hi <= i_hiData;
      if (i_loWe) r_lo <= i_loData;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mult_div_ctrl.sv
// ---------------------------------------------------------------------------
// mult_div_ctrl
// Purpose : Sequences the shared Booth multiplier and the divider for
//           MULT/MULTU/DIV instructions. Latches the operands, strobes the
//           selected unit's start input, waits for its busy flag to fall and
//           captures the result into HI/LO exactly once. Stalls the CPU while
//           busy, flags divide-by-zero and aborts on a watchdog timeout.
// Ports   : clk              rising-edge clock
//           reset            synchronous, active-high
//           op_mult          1-cycle multiply request
//           op_div           1-cycle divide request
//           fator_a/fator_b  operands (rs/rt)
//           mult_msb/lsb     multiplier product high/low word
//           mult_calculando  multiplier busy flag
//           div_quociente    divider quotient
//           div_resto        divider remainder
//           div_calculando   divider busy flag
//           op_a/op_b        latched operands driven to both units
//           mult_start       multiplier load strobe
//           div_start        divider load strobe
//           hi_out/lo_out    HI/LO registers
//           ocupado          stall request, high whenever not IDLE
//           pronto           1-cycle pulse, HI/LO just updated
//           div_zero         1-cycle pulse, DIV with zero divisor
//           erro             1-cycle pulse, watchdog timeout
// ---------------------------------------------------------------------------
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MAX_CICLOS = MAX_CICLOS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_mult,
  input  logic             op_div,
  input  logic [WIDTH-1:0] fator_a,
  input  logic [WIDTH-1:0] fator_b,
  input  logic [WIDTH-1:0] mult_msb,
  input  logic [WIDTH-1:0] mult_lsb,
  input  logic             mult_calculando,
  input  logic [WIDTH-1:0] div_quociente,
  input  logic [WIDTH-1:0] div_resto,
  input  logic             div_calculando,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             mult_start,
  output logic             div_start,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             ocupado,
  output logic             pronto,
  output logic             div_zero,
  output logic             erro
);

  ctrl_state_t      r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic             r_multStart;
  logic             r_divStart;
  logic             r_pronto;
  logic             r_divZero;
  logic             r_erro;
  logic [CNT_W-1:0] r_wdCount;

  logic             w_inWait;
  logic             w_unitBusy;
  logic             w_capture;
  logic [CNT_W-1:0] w_wdNext;
  logic             w_timeout;
  logic [WIDTH-1:0] w_hiData;
  logic [WIDTH-1:0] w_loData;

  // Only the unit that was started is watched; the other unit's flag is
  // irrelevant. Both units keep running after they finish, so the result
  // is taken on the first cycle the selected busy flag is low and never
  // again.
  assign w_inWait   = isWaitState(r_state);
  assign w_unitBusy = (r_state == M_WAIT) ? mult_calculando : div_calculando;
  assign w_capture  = w_inWait && !w_unitBusy;

  // The watchdog counts waiting cycles; the operation is abandoned on the
  // cycle whose increment would make the count reach MAX_CICLOS
  assign w_wdNext  = r_wdCount + CNT_W'(1);
  assign w_timeout = w_inWait && w_unitBusy && (w_wdNext == CNT_W'(MAX_CICLOS));

  // Multiplier writes its high/low product words; the divider writes the
  // remainder into HI and the quotient into LO
  assign w_hiData = (r_state == M_WAIT) ? mult_msb : div_resto;
  assign w_loData = (r_state == M_WAIT) ? mult_lsb : div_quociente;

  // Controller FSM with registered strobes and pulses. The start strobe is
  // raised on the edge that enters *_START so it is high for exactly that
  // state's cycle. The busy flag is never looked at in *_START because it
  // still reflects the previous operation until the unit loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_opA       <= '0;
      r_opB       <= '0;
      r_multStart <= 1'b0;
      r_divStart  <= 1'b0;
      r_pronto    <= 1'b0;
      r_divZero   <= 1'b0;
      r_erro      <= 1'b0;
      r_wdCount   <= '0;
    end else begin
      r_multStart <= 1'b0;
      r_divStart  <= 1'b0;
      r_pronto    <= 1'b0;
      r_divZero   <= 1'b0;
      r_erro      <= 1'b0;

      case (r_state)
        IDLE: begin
          if (op_mult) begin
            r_opA       <= fator_a;
            r_opB       <= fator_b;
            r_multStart <= 1'b1;
            r_state     <= M_START;
          end else if (op_div) begin
            if (fator_b == '0) begin
              r_divZero <= 1'b1;
            end else begin
              r_opA      <= fator_a;
              r_opB      <= fator_b;
              r_divStart <= 1'b1;
              r_state    <= D_START;
            end
          end
        end

        M_START: begin
          r_wdCount <= '0;
          r_state   <= M_WAIT;
        end

        D_START: begin
          r_wdCount <= '0;
          r_state   <= D_WAIT;
        end

        M_WAIT, D_WAIT: begin
          if (w_capture) begin
            r_pronto <= 1'b1;
            r_state  <= IDLE;
          end else if (w_timeout) begin
            r_erro  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_wdCount <= w_wdNext;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  hi_lo_regs #(
    .WIDTH (WIDTH)
  ) uHiLo (
    .clk      (clk),
    .reset    (reset),
    .i_hiWe   (w_capture),
    .i_loWe   (w_capture),
    .i_hiData (w_hiData),
    .i_loData (w_loData),
    .o_hi     (hi_out),
    .o_lo     (lo_out)
  );

  assign op_a       = r_opA;
  assign op_b       = r_opB;
  assign mult_start = r_multStart;
  assign div_start  = r_divStart;
  assign pronto     = r_pronto;
  assign div_zero   = r_divZero;
  assign erro       = r_erro;
  assign ocupado    = (r_state != IDLE);

endmodule
